// File: rtl/mmio_initiator.sv
// mmio_initiator: host-side MMIO requester used as the on-chip host model for
// loopback and self-test of an AFU register map.
//
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   cmd_*            one command at a time; valid/ready handshake, ready only in IDLE
//   mmio_wr_valid    one-cycle write request pulse toward the AFU
//   mmio_rd_valid    one-cycle read request pulse toward the AFU
//   mmio_addr/tid/wdata
//                    request fields, stable from one issue to the next
//   rsp_*            read responses from the AFU, matched by TID
//   done_*           one-cycle completion pulse with error flag and read data
//   unsolicited_cnt  saturating count of responses not matching an outstanding read
module mmio_initiator #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TID_W          = 9,
  parameter int ADDR_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [63:0]       cmd_wdata,
  output logic              mmio_wr_valid,
  output logic              mmio_rd_valid,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [TID_W-1:0]  mmio_tid,
  output logic [63:0]       mmio_wdata,
  input  logic              rsp_valid,
  input  logic [TID_W-1:0]  rsp_tid,
  input  logic [63:0]       rsp_data,
  output logic              done_valid,
  output logic              done_error,
  output logic [63:0]       done_rdata,
  output logic [7:0]        unsolicited_cnt
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RSP,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic              is_write;
  logic              err_q;
  logic [63:0]       rdata_q;
  logic [TID_W-1:0]  tid_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              accept;
  logic              rsp_match;
  logic              tmo_hit;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b0;
    done_valid    = 1'b0;
    accept        = 1'b0;
    rsp_match     = 1'b0;
    tmo_hit       = (tmo_cnt == TMO_LAST);
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          // Misaligned 64-bit access completes with an error without touching the bus.
          state_nxt = cmd_addr[0] ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (is_write) begin
          mmio_wr_valid = 1'b1;
          state_nxt     = S_DONE;
        end else begin
          mmio_rd_valid = 1'b1;
          state_nxt     = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        rsp_match = rsp_valid && (rsp_tid == mmio_tid);
        // A match on the expiry cycle still completes successfully.
        if (rsp_match || tmo_hit) state_nxt = S_DONE;
      end
      S_DONE: begin
        done_valid = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- control and request-field registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_write        <= 1'b0;
      err_q           <= 1'b0;
      mmio_addr       <= '0;
      mmio_tid        <= '0;
      mmio_wdata      <= '0;
      tid_cnt         <= '0;
      tmo_cnt         <= '0;
      unsolicited_cnt <= 8'd0;
    end else begin
      if (accept) begin
        is_write <= cmd_write;
        err_q    <= cmd_addr[0];
        // Request fields only move when a request will actually be issued.
        if (!cmd_addr[0]) begin
          mmio_addr  <= cmd_addr;
          mmio_tid   <= tid_cnt;
          mmio_wdata <= cmd_wdata;
        end
      end
      if (state == S_ISSUE && !is_write) begin
        tid_cnt <= tid_cnt + TID_W'(1);
        tmo_cnt <= '0;
      end
      if (state == S_WAIT_RSP) begin
        if (!tmo_hit) tmo_cnt <= tmo_cnt + TMO_W'(1);
        if (rsp_match)    err_q <= 1'b0;
        else if (tmo_hit) err_q <= 1'b1;
      end
      if (rsp_valid && !rsp_match) unsolicited_cnt <= sat_inc(unsolicited_cnt);
    end
  end

  // ---- read data capture (no reset; only observed through the DONE gate) ----
  always_ff @(posedge clk) begin
    if (accept)         rdata_q <= '0;
    else if (rsp_match) rdata_q <= rsp_data;
    else if (state == S_WAIT_RSP && tmo_hit) rdata_q <= '0;
  end

  assign done_error = done_valid & err_q;
  assign done_rdata = done_valid ? rdata_q : 64'd0;

endmodule
